// File: rtl/pred_table_ram.sv
// pred_table_ram: predictor table with multi-port combinational reads, an
// init sweep that loads INIT_VAL into every entry after reset or flush,
// and a 2-stage update pipeline that supports direct writes and
// saturating-counter updates with forwarding between back-to-back updates.
// Optional feature: define PRED_TABLE_BYPASS_EN so that reads return the
// pending stage-1 result when they hit the index being written.
`timescale 1ns/1ps
module pred_table_ram #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 2,
  parameter int RD_PORTS = 2,
  parameter int INIT_VAL = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic                         init_done,
  input  logic                         up_en,
  input  logic                         up_mode,
  input  logic [ADDR_W-1:0]            up_addr,
  input  logic [DATA_W-1:0]            up_data,
  input  logic                         up_taken
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] INIT_ENTRY = DATA_W'(INIT_VAL);
  localparam logic [DATA_W-1:0] MAX_ENTRY  = '1;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   sweep_ptr;
  logic [ADDR_W-1:0]   sweep_ptr_next;
  logic                sweep_we;

  logic [DATA_W-1:0]   tab [DEPTH];

  logic                s0_valid;
  logic [DATA_W-1:0]   s0_old;
  logic [DATA_W-1:0]   s0_result;

  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_addr;
  logic [DATA_W-1:0]   s1_result;
  logic                update_we;

  assign init_done = (state == ST_READY);
  assign update_we = s1_valid && !flush;

  // Sweep control: flush always restarts at entry 0, otherwise INIT walks one entry per cycle until the last one.
  always_comb begin
    state_next     = state;
    sweep_ptr_next = sweep_ptr;
    sweep_we       = 1'b0;
    if (flush) begin
      state_next     = ST_INIT;
      sweep_ptr_next = '0;
    end else if (state == ST_INIT) begin
      sweep_we       = 1'b1;
      sweep_ptr_next = sweep_ptr + ADDR_W'(1);
      if (sweep_ptr == LAST_IDX) begin
        state_next = ST_READY;
      end
    end
  end

  // Stage 0: accept a request only when ready, take "old" from the pending stage-1 result on an index match, compute the new entry.
  always_comb begin
    s0_valid  = up_en && init_done && !flush;
    s0_old    = (s1_valid && (s1_addr == up_addr)) ? s1_result : tab[up_addr];
    s0_result = up_data;
    if (up_mode) begin
      if (up_taken) begin
        s0_result = (s0_old == MAX_ENTRY) ? s0_old : s0_old + DATA_W'(1);
      end else begin
        s0_result = (s0_old == '0) ? s0_old : s0_old - DATA_W'(1);
      end
    end
  end

  // FSM state, sweep pointer and stage-1 pipeline register; reset aborts everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_result <= '0;
    end else begin
      state     <= state_next;
      sweep_ptr <= sweep_ptr_next;
      s1_valid  <= s0_valid;
      s1_addr   <= up_addr;
      s1_result <= s0_result;
    end
  end

  // Single table write port: the sweep owns it in INIT, stage 1 owns it in READY, nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (sweep_we) begin
        tab[sweep_ptr] <= INIT_ENTRY;
      end else if (update_we) begin
        tab[s1_addr] <= s1_result;
      end
    end
  end

  // Combinational read ports: INIT_VAL until the sweep completes, optionally bypassing the pending stage-1 write.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (!init_done) begin
        rd_data[p*DATA_W +: DATA_W] = INIT_ENTRY;
`ifdef PRED_TABLE_BYPASS_EN
      end else if (s1_valid && (rd_addr[p*ADDR_W +: ADDR_W] == s1_addr)) begin
        rd_data[p*DATA_W +: DATA_W] = s1_result;
`endif
      end else begin
        rd_data[p*DATA_W +: DATA_W] = tab[rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_pred_table_ram.sv
// tb_pred_table_ram: directed scenarios plus random traffic for
// pred_table_ram (ADDR_W=4), checked against a table-level reference model.
// Honours PRED_TABLE_BYPASS_EN when the design is built with it.
`timescale 1ns/1ps
module tb_pred_table_ram;

  localparam int AW    = 4;
  localparam int DW    = 2;
  localparam int RP    = 2;
  localparam int IV    = 1;
  localparam int DEPTH = 1 << AW;
  localparam int MAXV  = (1 << DW) - 1;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [RP*AW-1:0]  rd_addr;
  logic [RP*DW-1:0]  rd_data;
  logic              init_done;
  logic              up_en;
  logic              up_mode;
  logic [AW-1:0]     up_addr;
  logic [DW-1:0]     up_data;
  logic              up_taken;

  int checks;
  int errors;

  // Reference model: "logical" is the table as seen by a sequence of updates,
  // "visible" is what a plain read shows, lagging one edge behind acceptance.
  int initCount;
  int logical [DEPTH];
  int visible [DEPTH];
  bit pendValid;
  int pendAddr;
  int pendVal;

  pred_table_ram #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .RD_PORTS(RP),
    .INIT_VAL(IV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .init_done(init_done),
    .up_en(up_en),
    .up_mode(up_mode),
    .up_addr(up_addr),
    .up_data(up_data),
    .up_taken(up_taken)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    checks++;
    if (observed !== 32'(expected)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) begin
      logical[i] = IV;
      visible[i] = IV;
    end
    pendValid = 1'b0;
    initCount = 0;
  endtask

  function automatic bit modelDone();
    return initCount >= DEPTH;
  endfunction

  function automatic int expectedRead(input int a);
    if (!modelDone()) return IV;
`ifdef PRED_TABLE_BYPASS_EN
    if (pendValid && pendAddr == a) return pendVal;
`endif
    return visible[a];
  endfunction

  task automatic advanceModel(input bit en, input bit mode, input int ua, input int ud, input bit tk, input bit fl);
    int oldv;
    int newv;
    if (!modelDone()) begin
      if (fl) initCount = 0;
      else initCount++;
    end else begin
      if (pendValid && !fl) visible[pendAddr] = pendVal;
      pendValid = 1'b0;
      if (fl) begin
        modelClear();
      end else if (en) begin
        oldv = logical[ua];
        if (!mode) newv = ud;
        else if (tk) newv = (oldv == MAXV) ? MAXV : oldv + 1;
        else newv = (oldv == 0) ? 0 : oldv - 1;
        logical[ua] = newv;
        pendValid   = 1'b1;
        pendAddr    = ua;
        pendVal     = newv;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check mid-cycle, let the rising edge happen, advance the model.
  task automatic applyStimulus(input bit en, input bit mode, input int ua, input int ud,
                               input bit tk, input bit fl, input int ra0, input int ra1);
    up_en    = en;
    up_mode  = mode;
    up_addr  = AW'(ua);
    up_data  = DW'(ud);
    up_taken = tk;
    flush    = fl;
    rd_addr  = {AW'(ra1), AW'(ra0)};
    #1;
    checkOutput("init_done", 32'(init_done), int'(modelDone()));
    checkOutput("rd_port0", 32'(rd_data[DW-1:0]), expectedRead(ra0));
    checkOutput("rd_port1", 32'(rd_data[2*DW-1:DW]), expectedRead(ra1));
    @(posedge clk);
    advanceModel(en, mode, ua, ud, tk, fl);
    @(negedge clk);
  endtask

  task automatic idle(input int ra0, input int ra1);
    applyStimulus(0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  // Mid-cycle read on port 1 against a fixed expectation, no clock advance.
  task automatic probe(input string tag, input int addr, input int expected);
    up_en   = 1'b0;
    flush   = 1'b0;
    rd_addr = {AW'(addr), AW'(addr)};
    #1;
    checkOutput(tag, 32'(rd_data[2*DW-1:DW]), expected);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b1;
    modelClear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    flush = 1'b0;
    up_en = 1'b0;
    up_mode = 1'b0;
    up_addr = '0;
    up_data = '0;
    up_taken = 1'b0;
    rd_addr = '0;
    modelClear();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_init_done", 32'(init_done), 0);
    checkOutput("reset_rd0", 32'(rd_data[DW-1:0]), IV);
    checkOutput("reset_rd1", 32'(rd_data[2*DW-1:DW]), IV);

    // Sweep after reset release: 16 cycles low, then ready with every entry at INIT_VAL
    releaseReset();
    for (int i = 0; i < DEPTH; i++) idle(i, DEPTH - 1 - i);
    probe("sweep_done", 0, IV);
    checkOutput("init_done_after_sweep", 32'(init_done), 1);
    for (int i = 0; i < DEPTH; i++) begin
      probe("sweep_entry", i, IV);
      idle(i, DEPTH - 1 - i);
    end

    // Back-to-back saturating increments then decrements on index 3
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 3, 0, 1, 0, 3, 4);
    idle(3, 3);
    probe("sat_high", 3, MAXV);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 3, 0, 0, 0, 3, 2);
    idle(3, 3);
    probe("sat_low", 3, 0);

    // Direct write of 2 to index 5, read during the stage-1 cycle and the one after
    applyStimulus(1, 0, 5, 2, 0, 0, 5, 5);
`ifdef PRED_TABLE_BYPASS_EN
    probe("stage1_read", 5, 2);
`else
    probe("stage1_read", 5, IV);
`endif
    idle(5, 5);
    probe("after_write", 5, 2);

    // Flush while a write of 3 to index 7 sits in stage 1: write is lost
    applyStimulus(1, 0, 7, 3, 0, 0, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 7);
    for (int i = 0; i < DEPTH; i++) idle(7, 5);
    probe("flush_drops_write", 7, IV);
    probe("flush_resets_5", 5, IV);

    // Updates requested during INIT are ignored
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, i, 3, 0, 0, i, i + 8);
    for (int i = 5; i < DEPTH; i++) idle(i, 0);
    for (int i = 0; i < DEPTH; i++) begin
      probe("init_ignores_updates", i, IV);
      idle(i, i);
    end

    // Reset asserted at sweep pointer 8
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) idle(i, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midsweep_reset_done", 32'(init_done), 0);
    checkOutput("midsweep_reset_rd", 32'(rd_data[DW-1:0]), IV);
    releaseReset();
    for (int i = 0; i < DEPTH; i++) idle(i, 2);
    probe("resweep_done", 9, IV);
    checkOutput("resweep_init_done", 32'(init_done), 1);

    // Reset asserted mid-update: pending write aborted, init_done drops at once
    applyStimulus(1, 0, 2, 3, 0, 0, 2, 2);
    #2 reset = 1'b0;
    #1;
    checkOutput("midupdate_reset_done", 32'(init_done), 0);
    checkOutput("midupdate_reset_rd", 32'(rd_data[2*DW-1:DW]), IV);
    releaseReset();
    for (int i = 0; i < DEPTH; i++) idle(2, i);
    probe("midupdate_reset_entry", 2, IV);

    // Random traffic on a few aliasing indices
    for (int n = 0; n < 500; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, MAXV)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 79) == 0,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, DEPTH - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_table_ram.md
PRED_TABLE_RAM -- requirements
Module: pred_table_ram

Interface
REQ-001 Parameter ADDR_W, default 10: table index width; DEPTH = 2^ADDR_W entries.
REQ-002 Parameter DATA_W, default 2: entry width; minimum 2.
REQ-003 Parameter RD_PORTS, default 2: number of independent read ports; minimum 1.
REQ-004 Parameter INIT_VAL, default 1: value written to every entry by the init sweep.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-007 flush  input  1  single-cycle pulse; restarts the init sweep.
REQ-008 rd_addr  input  RD_PORTS*ADDR_W  read indices; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  RD_PORTS*DATA_W  read data, packed the same way as rd_addr.
REQ-010 init_done  output  1  high when the table is initialised and accepting updates.
REQ-011 up_en  input  1  update request, sampled on the rising edge.
REQ-012 up_mode  input  1  0 = direct write of up_data; 1 = saturating-counter update.
REQ-013 up_addr  input  ADDR_W  update index.
REQ-014 up_data  input  DATA_W  write data, used only when up_mode=0.
REQ-015 up_taken  input  1  counter direction when up_mode=1: 1 = increment, 0 = decrement.

Function
REQ-016 FSM states: INIT (sweep) and READY; reset deassertion and flush both enter INIT with sweep pointer 0.
REQ-017 INIT writes INIT_VAL to one entry per cycle, pointer 0 to DEPTH-1; after DEPTH cycles the FSM moves to READY and init_done rises.
REQ-018 Flush received in any state, including mid-sweep, restarts the sweep at 0 on the next cycle.
REQ-019 Reads are combinational: rd_data[p] = tab[rd_addr[p]] in the same cycle; all ports are independent and may alias the same index.
REQ-020 While init_done=0, every rd_data port returns INIT_VAL regardless of table contents.
REQ-021 While init_done=0, up_en is ignored; no state changes, and the request is not queued.
REQ-022 Updates use a 2-stage pipeline, one accepted per cycle.
  - Stage 0 captures addr, mode, data, direction, and reads the old entry.
  - Stage 1 writes the result; the table changes at the end of the cycle after acceptance.
REQ-023 Mode 0 result = up_data.
REQ-024 Mode 1 result = old+1 when taken, old-1 when not taken.
  - Saturates at 2^DATA_W-1 and at 0; no wrap-around.
REQ-025 Back-to-back updates to the same index: stage 0 uses stage 1's pending result as "old" (forwarding), so N consecutive increments from 0 yield min(N, max).
REQ-026 Flush arriving while stage 1 is valid discards the pending write; the sweep owns the write port.
REQ-027 The sweep write and the update write never occur in the same cycle.

Reset
REQ-028 Reset asserted: FSM=INIT, sweep pointer=0, init_done=0, stage-0/stage-1 valid=0, rd_data=INIT_VAL on all ports.
REQ-029 Table contents are not reset directly; they are defined only by the sweep.
REQ-030 Reset asserted mid-sweep or mid-update aborts all activity; the full sweep reruns after deassertion.

Configuration
REQ-031 With macro PRED_TABLE_BYPASS_EN defined, a read port whose rd_addr equals the stage-1 write index in that cycle returns the stage-1 result (write-to-read bypass).
REQ-032 Without PRED_TABLE_BYPASS_EN, that read returns the old stored value; the new value is visible from the following cycle.

Verification
REQ-033 Reset release, ADDR_W=4 -> init_done=0 for 16 cycles then 1; every index reads 1.
REQ-034 Mode 1, taken, index 3, four consecutive cycles from 1 -> entry reads 3 (saturated); four untaken updates then -> 0.
REQ-035 Mode 0 write 2 to index 5, rd_addr port1=5 during the stage-1 cycle -> reads 2 with PRED_TABLE_BYPASS_EN, 1 without; 2 next cycle in both builds.
REQ-036 Flush asserted while a mode-0 write of 3 to index 7 is in stage 1 -> write lost; after re-sweep index 7 reads 1.
REQ-037 up_en held for 5 cycles during INIT -> no entry changes; after init_done all entries read INIT_VAL.
REQ-038 Reset asserted at sweep pointer 8 -> outputs return to reset values immediately; sweep restarts at 0 after release.
